// File: rtl/sr_pkg.sv
// Shared definitions for the shift-register sequencer and the shift-register top.
package sr_pkg;
  localparam int SR_WIDTH     = 170;
  localparam int SR_CFG_WIDTH = 16;
  localparam int SR_DIV_WIDTH = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_LOAD,
    S_WAIT_END,
    S_DONE
  } state_t;

  function automatic int nwords(input int width, input int cfg_width);
    return (width + cfg_width - 1) / cfg_width;
  endfunction
endpackage

// File: rtl/sr_cfg_buffer.sv
// Word-shift configuration buffer: new words enter at the LSBs, the first word
// written ends up MSB-most. word_cnt saturates at the number of words needed.
module sr_cfg_buffer
  import sr_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter int CFG_WIDTH = SR_CFG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 clr,
  input  logic [CFG_WIDTH-1:0] din,
  output logic [WIDTH-1:0]     data,
  output logic [3:0]           word_cnt
);
  localparam logic [3:0] NW_CNT = 4'(nwords(WIDTH, CFG_WIDTH));

  // Bits above WIDTH can never reach data, so only the low WIDTH bits are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data     <= '0;
      word_cnt <= '0;
    end else if (clr) begin
      data     <= '0;
      word_cnt <= '0;
    end else if (wr_en) begin
      data <= WIDTH'({data, din});
      if (word_cnt != NW_CNT) word_cnt <= word_cnt + 4'd1;
    end
  end
endmodule

// File: rtl/sr_sequencer.sv
// Sequencer that programs a shift-register chain: collects config words, holds
// start for two divided-clock periods, then tracks the load_sr handshake.
module sr_sequencer
  import sr_pkg::*;
#(
  parameter int WIDTH         = SR_WIDTH,
  parameter int CFG_WIDTH     = SR_CFG_WIDTH,
  parameter int DIV_WIDTH     = SR_DIV_WIDTH,
  parameter int COUNT_WIDTH   = 64,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 cfg_wr_en,
  input  logic [CFG_WIDTH-1:0] cfg_din,
  input  logic                 cfg_clr,
  input  logic                 go,
  input  logic                 abort,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 load_sr,
  output logic [WIDTH-1:0]     sr_din,
  output logic                 sr_start,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           word_cnt,
  output logic                 cfg_err,
  output logic                 timeout_err
);
  localparam logic [3:0] NW_CNT = 4'(nwords(WIDTH, CFG_WIDTH));

  state_t                   state, state_d;
  logic                     load_q, load_seen, load_rise, load_fall;
  logic [COUNT_WIDTH-1:0]   hold_cnt, hold_last;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic                     in_idle, waiting, go_bad, tmo_hit;

  assign in_idle   = (state == S_IDLE);
  assign waiting   = (state == S_WAIT_LOAD) || (state == S_WAIT_END);
  assign load_rise = load_sr & ~load_q;
  assign load_fall = ~load_sr & load_q;
  assign tmo_hit   = waiting && (&tmo_cnt) && !abort;
  assign busy      = !in_idle;
  assign done      = (state == S_DONE);

  sr_cfg_buffer #(
    .WIDTH     (WIDTH),
    .CFG_WIDTH (CFG_WIDTH)
  ) u_buf (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .wr_en    (cfg_wr_en && in_idle),
    .clr      (cfg_clr && in_idle),
    .din      (cfg_din),
    .data     (sr_din),
    .word_cnt (word_cnt)
  );

  // Last hold-counter index: 2^(div+1)-1, saturating so HOLD tops out at all-ones.
  always_comb begin
    if (int'(div) >= COUNT_WIDTH - 1) hold_last = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};
    else hold_last = (COUNT_WIDTH'(1) << (int'(div) + 1)) - COUNT_WIDTH'(1);
  end

  always_comb begin
    state_d = state;
    go_bad  = 1'b0;
    case (state)
      S_IDLE:
        if (go && !cfg_clr) begin
          if (word_cnt == NW_CNT) state_d = S_START;
          else go_bad = 1'b1;
        end
      S_START:
        if (hold_cnt == hold_last) state_d = (load_seen || load_rise) ? S_WAIT_END : S_WAIT_LOAD;
      S_WAIT_LOAD:
        if (&tmo_cnt) state_d = S_IDLE;
        else if (load_rise) state_d = S_WAIT_END;
      S_WAIT_END:
        if (&tmo_cnt) state_d = S_IDLE;
        else if (load_fall) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && !in_idle) state_d = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sr_start <= 1'b0;
    end else begin
      state    <= state_d;
      sr_start <= (state_d == S_START);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      load_q      <= 1'b0;
      load_seen   <= 1'b0;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      load_q    <= load_sr;
      // A load edge arriving while start is still held must not be lost.
      load_seen <= (state == S_START) && (load_seen || load_rise);
      hold_cnt  <= (state == S_START) ? hold_cnt + COUNT_WIDTH'(1) : '0;
      tmo_cnt   <= waiting ? tmo_cnt + TIMEOUT_WIDTH'(1) : '0;
      if (cfg_clr && in_idle) begin
        cfg_err     <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (go_bad || (cfg_wr_en && !in_idle)) cfg_err <= 1'b1;
        if (tmo_hit) timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sr_sequencer.sv
// Randomized self-checking bench for sr_sequencer against a word-queue model.
module tb_sr_sequencer;
  import sr_pkg::*;
  localparam int W = 170, CW = 16, DW = 6, NW = 11;

  logic          clk_in = 1'b0, rst_n = 1'b0;
  logic          cfg_wr_en = 1'b0, cfg_clr = 1'b0, go = 1'b0, abort = 1'b0, load_sr = 1'b0;
  logic [CW-1:0] cfg_din = '0;
  logic [DW-1:0] div = '0;
  logic [W-1:0]  sr_din;
  logic          sr_start, busy, done, cfg_err, timeout_err;
  logic [3:0]    word_cnt;

  sr_sequencer #(
    .WIDTH(W), .CFG_WIDTH(CW), .DIV_WIDTH(DW), .COUNT_WIDTH(64), .TIMEOUT_WIDTH(8)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_din(cfg_din),
    .cfg_clr(cfg_clr), .go(go), .abort(abort), .div(div), .load_sr(load_sr),
    .sr_din(sr_din), .sr_start(sr_start), .busy(busy), .done(done),
    .word_cnt(word_cnt), .cfg_err(cfg_err), .timeout_err(timeout_err)
  );

  always #5 clk_in = ~clk_in;

  int          n_tests = 0, n_fail = 0;
  logic [15:0] mq[$];
  int          m_wc = 0;
  bit          m_err = 0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Expected chain data: the last NW words, oldest most significant.
  function automatic logic [W-1:0] model_din();
    logic [NW*CW-1:0] acc = '0;
    foreach (mq[i]) acc = {acc[NW*CW-CW-1:0], mq[i]};
    return acc[W-1:0];
  endfunction

  task automatic wr_word(input logic [15:0] w);
    cfg_din = w; cfg_wr_en = 1'b1; tick(); cfg_wr_en = 1'b0;
    mq.push_back(w);
    if (mq.size() > NW) void'(mq.pop_front());
    if (m_wc < NW) m_wc++;
  endtask

  task automatic do_clr();
    cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
    mq.delete(); m_wc = 0; m_err = 0;
  endtask

  // One full programming sequence; load_sr rises either during START (early)
  // or dly cycles after start falls, and stays high for len cycles.
  task automatic run_seq(input bit early, input int dly, input int len);
    logic [W-1:0] din0;
    int  n, hold;
    bit  bad_done = 0, bad_din = 0, bad_busy = 0;
    hold = 1 << (int'(div) + 1);
    din0 = sr_din;
    go = 1'b1; tick(); go = 1'b0;
    chk("start_rise", sr_start, 1);
    if (early) load_sr = 1'b1;
    n = 1;
    for (int i = 0; i < 300 && sr_start; i++) begin
      tick();
      if (sr_start) n++;
      if (sr_din !== din0) bad_din = 1;
      if (!busy) bad_busy = 1;
      if (done) bad_done = 1;
    end
    chk("hold_len", n, hold);
    if (!early) begin
      repeat (dly) begin
        tick();
        if (!busy) bad_busy = 1;
        if (done) bad_done = 1;
      end
      load_sr = 1'b1;
    end
    repeat (len) begin
      tick();
      if (!busy) bad_busy = 1;
      if (done) bad_done = 1;
      if (sr_din !== din0) bad_din = 1;
    end
    load_sr = 1'b0;
    tick();
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("no_early_done", bad_done, 0);
    chk("din_stable", bad_din || (sr_din !== din0), 0);
    chk("busy_held", bad_busy, 0);
  endtask

  initial begin
    logic [W-1:0] din0;
    int  n;
    bit  saw_done, pre_err;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", sr_start, 0);
    chk("rst_done", done, 0);
    chk("rst_wc", word_cnt, 0);
    chk("rst_errs", {cfg_err, timeout_err}, 0);
    chk("rst_din", sr_din, 0);
    #3 rst_n = 1'b1;
    tick();

    // Eleven ascending words, div=2 -> 8-cycle start hold.
    for (int i = 1; i <= NW; i++) wr_word(16'(i));
    chk("wc_full", word_cnt, NW);
    chk("din_lsw", sr_din[15:0], 16'h000B);
    chk("din_w2", sr_din[31:16], 16'h000A);
    chk("din_msb", sr_din[169:160], 10'h001);
    chk("din_model", sr_din, model_din());
    div = 6'd2;
    run_seq(1'b0, 20, 4);
    chk("seq1_err", cfg_err, 0);
    // Re-issue without reloading: identical data.
    run_seq(1'b0, 20, 4);
    chk("rego_din", sr_din, model_din());
    chk("rego_wc", word_cnt, NW);

    // Short load: go rejected.
    do_clr();
    for (int i = 0; i < 10; i++) wr_word(16'($urandom));
    go = 1'b1; tick(); go = 1'b0;
    m_err = 1;
    chk("short_err", cfg_err, 1);
    chk("short_start", sr_start, 0);
    chk("short_busy", busy, 0);
    tick();
    chk("short_start2", sr_start, 0);
    wr_word(16'($urandom));
    run_seq(1'b0, 5, 3);
    chk("short_din", sr_din, model_din());
    chk("short_err_sticky", cfg_err, 1);

    // Timeout with load_sr held low.
    do_clr();
    for (int i = 0; i < NW; i++) wr_word(16'($urandom));
    div = 6'd1;
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 100 && sr_start; i++) tick();
    n = 0; saw_done = 0; pre_err = 1;
    for (int i = 0; i < 400 && busy; i++) begin
      n++;
      if (n == 200) pre_err = timeout_err;
      if (done) saw_done = 1;
      tick();
    end
    chk("tmo_not_early", pre_err, 0);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_no_done", saw_done, 0);
    chk("tmo_len", (n >= 255 && n <= 257), 1);
    do_clr();
    chk("clr_errs", {cfg_err, timeout_err}, 0);

    // Write during START, then abort on START cycle 3.
    for (int i = 0; i < NW; i++) wr_word(16'($urandom));
    div = 6'd2;
    din0 = sr_din;
    go = 1'b1; tick(); go = 1'b0;
    cfg_din = 16'hBEEF; cfg_wr_en = 1'b1; tick(); cfg_wr_en = 1'b0;
    m_err = 1;
    chk("busy_wr_err", cfg_err, 1);
    chk("busy_wr_din", sr_din, din0);
    chk("busy_wr_wc", word_cnt, NW);
    tick();
    chk("start_c3", sr_start, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_start", sr_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err_kept", cfg_err, 1);
    tick();
    chk("abort_no_done", done, 0);

    // Reset in WAIT_END.
    div = 6'd0;
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 100 && sr_start; i++) tick();
    load_sr = 1'b1; tick(); tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {sr_start, busy, done, cfg_err, timeout_err, word_cnt}, 0);
    chk("mid_rst_din", sr_din, 0);
    load_sr = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    mq.delete(); m_wc = 0; m_err = 0;
    chk("post_rst_idle", busy, 0);
    for (int i = 0; i < 3; i++) wr_word(16'($urandom));
    chk("wc_three", word_cnt, 3);
    cfg_din = 16'h1234; cfg_clr = 1'b1; cfg_wr_en = 1'b1; tick();
    cfg_clr = 1'b0; cfg_wr_en = 1'b0;
    mq.delete(); m_wc = 0;
    chk("clr_wins_wc", word_cnt, 0);
    chk("clr_wins_din", sr_din, 0);

    // Random mix of loads, clears and sequences.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) do_clr();
      repeat ($urandom_range(0, 6)) wr_word(16'($urandom));
      div = 6'($urandom_range(0, 4));
      if (m_wc == NW) run_seq(1'($urandom_range(0, 1)), $urandom_range(0, 30), $urandom_range(1, 8));
      else begin
        go = 1'b1; tick(); go = 1'b0;
        m_err = 1;
        chk("rnd_short_busy", busy, 0);
      end
      chk("rnd_din", sr_din, model_din());
      chk("rnd_wc", word_cnt, m_wc);
      chk("rnd_err", cfg_err, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
